// File: rtl/daq_dma_arbiter_pkg.sv
// Shared definitions for the DAQ DMA packet arbiter: FSM encodings, truncation marker and status packing.
// DRAIN has no encoding of its own; it is ST_TRUNC with the drain flag set.
package daq_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRUNC = 2'd3
  } arb_state_e;

  localparam logic [31:0] TRUNC_MARKER = 32'hDEADDEAD;

  localparam int STAT_ERR_BIT   = 11;
  localparam int STAT_GRANT_LSB = 7;
  localparam int STAT_GVLD_BIT  = 6;
  localparam int STAT_STATE_LSB = 4;

  function automatic logic [11:0] pack_status(input logic       err,
                                              input logic [2:0] grant,
                                              input logic       gvld,
                                              input arb_state_e st);
    pack_status                            = '0;
    pack_status[STAT_ERR_BIT]              = err;
    pack_status[STAT_GRANT_LSB +: 3]       = grant;
    pack_status[STAT_GVLD_BIT]             = gvld;
    pack_status[STAT_STATE_LSB +: 2]       = st;
  endfunction

endpackage

// File: rtl/daq_dma_arbiter_rr_pick.sv
// Rotate-priority encoder: returns the first requester after 'last', wrapping around.
// Kept standalone so other link arbiters can reuse it.
module daq_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/daq_dma_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC DMA-manager streams into one host DMA stream.
// Define DAQ_DMA_ARB_TIMEOUT_EN to add the mid-packet stall timeout (TRUNC marker + DRAIN).
module daq_dma_arbiter
  import daq_dma_arbiter_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         dma_data,
  output logic                      dma_valid,
  output logic                      dma_last,
  input  logic                      dma_ready,
  output logic [15:0]               pkt_count,
  output logic [11:0]               status
);

  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("daq_dma_arbiter: parameter out of range");
  end

  arb_state_e        state_q;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     last_grant_q;
  logic              grant_vld_q;
  logic [15:0]       pkt_cnt_q;
  logic              err_sticky;

  logic [NUM_SRC-1:0] req;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  src_word [NUM_SRC];
  logic               g_valid;
  logic               g_last;
  logic               xfer_done;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*DATA_W +: DATA_W];
  end

  assign req       = src_valid & src_mask;
  assign g_valid   = src_valid[grant_q];
  assign g_last    = src_last[grant_q];
  assign xfer_done = (state_q == ST_XFER) && g_valid && dma_ready && g_last;

  daq_rr_pick #(.N(NUM_SRC), .IW(GW)) u_pick (
    .req  (req),
    .last (last_grant_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef DAQ_DMA_ARB_TIMEOUT_EN
  logic [15:0] stall_q;
  logic        drain_q;
  logic        err_q;
  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

  // Data path is a combinational pass-through of the granted source while in XFER.
  always_comb begin
    dma_data  = '0;
    dma_valid = 1'b0;
    dma_last  = 1'b0;
    src_ready = '0;
    if (state_q == ST_XFER) begin
      dma_data           = src_word[grant_q];
      dma_valid          = g_valid;
      dma_last           = g_last;
      src_ready[grant_q] = dma_ready;
    end
`ifdef DAQ_DMA_ARB_TIMEOUT_EN
    else if (state_q == ST_TRUNC) begin
      if (drain_q) begin
        src_ready[grant_q] = 1'b1;
      end else begin
        dma_valid = 1'b1;
        dma_last  = 1'b1;
        dma_data  = DATA_W'({TRUNC_MARKER, 29'h0, 3'(grant_q)});
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      grant_vld_q  <= 1'b0;
      pkt_cnt_q    <= '0;
`ifdef DAQ_DMA_ARB_TIMEOUT_EN
      stall_q      <= '0;
      drain_q      <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (enable && |req) state_q <= ST_ARB;
        ST_ARB: begin
          // The requester seen in IDLE may have dropped valid; fall back rather than grant nobody.
          if (pick_any) begin
            grant_q      <= pick_idx;
            last_grant_q <= pick_idx;
            grant_vld_q  <= 1'b1;
            state_q      <= ST_XFER;
`ifdef DAQ_DMA_ARB_TIMEOUT_EN
            stall_q      <= '0;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (xfer_done) begin
            pkt_cnt_q   <= pkt_cnt_q + 16'd1;
            grant_vld_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
`ifdef DAQ_DMA_ARB_TIMEOUT_EN
          else if (g_valid) begin
            stall_q <= '0;
          end else if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
            stall_q <= '0;
            state_q <= ST_TRUNC;
          end else begin
            stall_q <= stall_q + 16'd1;
          end
`endif
        end
`ifdef DAQ_DMA_ARB_TIMEOUT_EN
        ST_TRUNC: begin
          if (!drain_q) begin
            if (dma_ready) begin
              drain_q   <= 1'b1;
              err_q     <= 1'b1;
              pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
          end else if (g_valid && g_last) begin
            drain_q     <= 1'b0;
            grant_vld_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign status    = pack_status(err_sticky, 3'(grant_q), grant_vld_q, state_q);

endmodule
